imem_fetch_ctrl: RTL and testbench

Fetch sequencer for the byte-organised 256-entry instruction memory of the 16-bit single-cycle CPU. It owns the program counter and issues two byte reads per instruction: high byte at PC, low byte at PC+1. It assembles each 16-bit big-endian instruction word and presents it to decode over a valid/ready handshake. It also handles branch/jump redirects, the halt word, and misaligned redirect targets.

---
 rtl/imem_fetch_ctrl.sv | 164 ++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Fetch sequencer for the byte-wide instruction memory of the 16-bit CPU.
// Owns the PC and reads two bytes per instruction: the high byte at PC and
// the low byte at PC+1. It then presents the big-endian word to decode over
// a valid/ready handshake. Redirects take priority in every state.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ISSUE_HI   | high-byte read at pc is on the bus. If mem_rd_en is still
//            | low (only right after reset), this cycle primes the strobe.
// ISSUE_LO   | low-byte read at pc+1 is on the bus; high byte returns now
// CAPTURE_LO | low byte returns; assemble word, check for halt
// PRESENT    | instr_valid high, hold word until decode accepts it
// HALT       | halt word seen; idle until redirect or reset

module imem_fetch_ctrl #(
   parameter int unsigned ADDR_W    = 8,
   parameter logic [15:0] RESET_PC  = 16'h0002,
   parameter bit          HALT_EN   = 1'b1,
   parameter logic [15:0] HALT_WORD = 16'h0000
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [7:0]        mem_rdata,
   output logic [15:0]       instr,
   output logic [15:0]       instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect_valid,
   input  logic [15:0]       redirect_pc,
   output logic              halted,
   output logic              align_err,
   output logic [15:0]       fetch_count
);

   typedef enum logic [2:0] {
      S_ISSUE_HI   = 3'd0,
      S_ISSUE_LO   = 3'd1,
      S_CAPTURE_LO = 3'd2,
      S_PRESENT    = 3'd3,
      S_HALT       = 3'd4
   } state_t;

   state_t            r_state;
   logic [15:0]       r_pc;
   logic [7:0]        r_hi_byte;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_rd_en;
   logic [15:0]       r_instr;
   logic [15:0]       r_instr_pc;
   logic              r_instr_valid;
   logic              r_halted;
   logic              r_align_err;
   logic [15:0]       r_fetch_count;

   logic [15:0]       w_pc_plus2;
   logic [ADDR_W-1:0] w_addr_lo;
   logic [15:0]       w_redirect_pc;
   logic [15:0]       w_word;
   logic              w_accept;
   logic              w_is_halt;

   // PC arithmetic is 16-bit wrapping; memory address wraps at ADDR_W bits.
   assign w_pc_plus2    = r_pc + 16'd2;
   assign w_addr_lo     = r_pc[ADDR_W-1:0] + ADDR_W'(1);
   assign w_redirect_pc = {redirect_pc[15:1], 1'b0};
   assign w_word        = {r_hi_byte, mem_rdata};
   assign w_accept      = (r_state == S_PRESENT) && instr_ready;
   assign w_is_halt     = HALT_EN && (w_word == HALT_WORD);

   // Fetch FSM with all outputs registered; redirect overrides every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_ISSUE_HI;
         r_pc          <= RESET_PC;
         r_hi_byte     <= 8'h00;
         r_mem_addr    <= RESET_PC[ADDR_W-1:0];
         r_mem_rd_en   <= 1'b0;
         r_instr       <= 16'h0000;
         r_instr_pc    <= 16'h0000;
         r_instr_valid <= 1'b0;
         r_halted      <= 1'b0;
         r_align_err   <= 1'b0;
         r_fetch_count <= 16'h0000;
      end else begin
         r_align_err <= 1'b0;

         // Acceptance counts even when a redirect lands in the same cycle.
         if (w_accept) begin
            r_fetch_count <= r_fetch_count + 16'd1;
         end

         if (redirect_valid) begin
            // Byte reads still in flight return into ISSUE_HI and are ignored.
            r_state       <= S_ISSUE_HI;
            r_pc          <= w_redirect_pc;
            r_mem_addr    <= w_redirect_pc[ADDR_W-1:0];
            r_mem_rd_en   <= 1'b1;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_align_err   <= redirect_pc[0];
         end else begin
            case (r_state)
               S_ISSUE_HI: begin
                  if (!r_mem_rd_en) begin
                     // First cycle out of reset: put the high-byte read on the bus.
                     r_mem_rd_en <= 1'b1;
                     r_mem_addr  <= r_pc[ADDR_W-1:0];
                  end else begin
                     r_mem_addr <= w_addr_lo;
                     r_state    <= S_ISSUE_LO;
                  end
               end
               S_ISSUE_LO: begin
                  r_hi_byte   <= mem_rdata;
                  r_mem_rd_en <= 1'b0;
                  r_state     <= S_CAPTURE_LO;
               end
               S_CAPTURE_LO: begin
                  r_instr    <= w_word;
                  r_instr_pc <= r_pc;
                  if (w_is_halt) begin
                     r_halted <= 1'b1;
                     r_state  <= S_HALT;
                  end else begin
                     r_instr_valid <= 1'b1;
                     r_state       <= S_PRESENT;
                  end
               end
               S_PRESENT: begin
                  if (instr_ready) begin
                     r_pc          <= w_pc_plus2;
                     r_mem_addr    <= w_pc_plus2[ADDR_W-1:0];
                     r_mem_rd_en   <= 1'b1;
                     r_instr_valid <= 1'b0;
                     r_state       <= S_ISSUE_HI;
                  end
               end
               S_HALT: begin
                  r_mem_rd_en   <= 1'b0;
                  r_instr_valid <= 1'b0;
               end
               default: begin
                  r_mem_rd_en   <= 1'b0;
                  r_instr_valid <= 1'b0;
                  r_state       <= S_ISSUE_HI;
               end
            endcase
         end
      end
   end

   assign mem_addr    = r_mem_addr;
   assign mem_rd_en   = r_mem_rd_en;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_instr_valid;
   assign halted      = r_halted;
   assign align_err   = r_align_err;
   assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a registered-read byte memory.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  mem_addr;
   logic        mem_rd_en;
   logic [7:0]  mem_rdata = 8'h00;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        halted;
   logic        align_err;
   logic [15:0] fetch_count;

   logic [7:0]  mem [256];
   int          n_chk  = 0;
   int          n_pass = 0;
   int          n_align;

   imem_fetch_ctrl #(
      .ADDR_W(8), .RESET_PC(16'h0002), .HALT_EN(1'b1), .HALT_WORD(16'h0000)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halted(halted), .align_err(align_err), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   // memory returns the addressed byte in the cycle after the strobe
   always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_issue(input string tag, input logic [7:0] addr);
      chk({tag, "_rd"}, 32'(mem_rd_en), 32'h1);
      chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
   endtask

   task automatic chk_present(input string tag, input logic [15:0] w, input logic [15:0] pc);
      chk({tag, "_valid"}, 32'(instr_valid), 32'h1);
      chk({tag, "_instr"}, 32'(instr), 32'(w));
      chk({tag, "_pc"}, 32'(instr_pc), 32'(pc));
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_rd"}, 32'(mem_rd_en), 32'h0);
      chk({tag, "_addr"}, 32'(mem_addr), 32'h02);
      chk({tag, "_instr"}, 32'(instr), 32'h0);
      chk({tag, "_ipc"}, 32'(instr_pc), 32'h0);
      chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
      chk({tag, "_halted"}, 32'(halted), 32'h0);
      chk({tag, "_align"}, 32'(align_err), 32'h0);
      chk({tag, "_count"}, 32'(fetch_count), 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'hA5;
      mem[8'h00] = 8'h77; mem[8'h01] = 8'h88;
      mem[8'h02] = 8'h31; mem[8'h03] = 8'h12;
      mem[8'h04] = 8'h45; mem[8'h05] = 8'h67;
      mem[8'h1C] = 8'h00; mem[8'h1D] = 8'h00;
      mem[8'h26] = 8'h01; mem[8'h27] = 8'h23;
      mem[8'h28] = 8'h50; mem[8'h29] = 8'h4A;
      mem[8'hFE] = 8'h9A; mem[8'hFF] = 8'hBC;

      rst_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0;
      step(); step();
      chk_reset_outs("rst");

      // first fetch from RESET_PC
      @(negedge clk) rst_n = 1'b1;
      step(); chk_issue("f0_hi", 8'h02);
      step(); chk_issue("f0_lo", 8'h03);
      step(); chk("f0_cap_rd", 32'(mem_rd_en), 32'h0);
      chk("f0_cap_valid", 32'(instr_valid), 32'h0);
      step(); chk_present("f0", 16'h3112, 16'h0002);
      chk("f0_count", 32'(fetch_count), 32'h0);
      step(); chk_issue("f1_hi", 8'h04);
      chk("f1_count", 32'(fetch_count), 32'h1);
      chk("f1_valid", 32'(instr_valid), 32'h0);

      // stall five cycles in PRESENT
      instr_ready = 1'b0;
      step(); step(); step();
      chk_present("stall0", 16'h4567, 16'h0004);
      for (int i = 0; i < 5; i++) begin
         step();
         chk_present("stall", 16'h4567, 16'h0004);
         chk("stall_rd", 32'(mem_rd_en), 32'h0);
         chk("stall_count", 32'(fetch_count), 32'h1);
      end
      instr_ready = 1'b1;
      step(); chk_issue("post_stall", 8'h06);
      chk("post_stall_count", 32'(fetch_count), 32'h2);

      // redirect while the low byte is being issued
      step(); chk_issue("pre_redir_lo", 8'h07);
      redirect_valid = 1'b1; redirect_pc = 16'h0026;
      step(); chk_issue("r26_hi", 8'h26);
      chk("r26_align", 32'(align_err), 32'h0);
      redirect_valid = 1'b0;
      step(); chk_issue("r26_lo", 8'h27);
      step();
      step(); chk_present("r26", 16'h0123, 16'h0026);
      chk("r26_count", 32'(fetch_count), 32'h2);
      step(); chk_issue("post_r26", 8'h28);
      chk("post_r26_count", 32'(fetch_count), 32'h3);

      // misaligned redirect
      redirect_valid = 1'b1; redirect_pc = 16'h0029;
      n_align = 0;
      step(); chk_issue("r29_hi", 8'h28);
      chk("r29_align_pulse", 32'(align_err), 32'h1);
      n_align += int'(align_err);
      redirect_valid = 1'b0;
      step(); chk_issue("r29_lo", 8'h29); n_align += int'(align_err);
      step(); n_align += int'(align_err);
      step(); chk_present("r29", 16'h504A, 16'h0028); n_align += int'(align_err);
      chk("r29_align_once", 32'(n_align), 32'h1);
      step(); chk("post_r29_count", 32'(fetch_count), 32'h4);

      // halt word at 0x1C
      redirect_valid = 1'b1; redirect_pc = 16'h001C;
      step(); chk_issue("h_hi", 8'h1C);
      redirect_valid = 1'b0;
      step(); chk_issue("h_lo", 8'h1D);
      step();
      step(); chk("h_halted", 32'(halted), 32'h1);
      chk("h_valid", 32'(instr_valid), 32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("h_hold_rd", 32'(mem_rd_en), 32'h0);
         chk("h_hold_halted", 32'(halted), 32'h1);
         chk("h_hold_valid", 32'(instr_valid), 32'h0);
      end
      chk("h_count", 32'(fetch_count), 32'h4);
      redirect_valid = 1'b1; redirect_pc = 16'h0002;
      step(); chk("h_resume_halted", 32'(halted), 32'h0);
      chk_issue("h_resume", 8'h02);
      redirect_valid = 1'b0;
      step(); step();
      step(); chk_present("h_resume", 16'h3112, 16'h0002);
      step(); chk("h_resume_count", 32'(fetch_count), 32'h5);

      // PC crossing the 8-bit memory address boundary
      redirect_valid = 1'b1; redirect_pc = 16'h00FE;
      step(); chk_issue("w_hi", 8'hFE);
      redirect_valid = 1'b0;
      step(); chk_issue("w_lo", 8'hFF);
      step();
      step(); chk_present("w_fe", 16'h9ABC, 16'h00FE);
      step(); chk_issue("w_wrap_hi", 8'h00);
      step(); chk_issue("w_wrap_lo", 8'h01);
      step();
      step(); chk_present("w_100", 16'h7788, 16'h0100);

      // accept and redirect in the same cycle
      redirect_valid = 1'b1; redirect_pc = 16'h0026;
      step(); chk("rr_count", 32'(fetch_count), 32'h7);
      chk_issue("rr", 8'h26);
      chk("rr_valid", 32'(instr_valid), 32'h0);
      redirect_valid = 1'b0;

      // asynchronous reset during CAPTURE_LO
      step(); step();
      rst_n = 1'b0;
      #1;
      chk_reset_outs("arst");
      @(negedge clk) rst_n = 1'b1;
      step(); chk_issue("arst_hi", 8'h02);
      step(); chk_issue("arst_lo", 8'h03);
      step();
      step(); chk_present("arst", 16'h3112, 16'h0002);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
